// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath (LIF neuron and STDP stage).
package snn_pkg;

  localparam int DEF_NUM_PRE   = 4;
  localparam int DEF_W_WIDTH   = 4;
  localparam int DEF_V_WIDTH   = 8;
  localparam int SPIKE_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    INTEGRATE  = 2'd1,
    REFRACTORY = 2'd2
  } lif_state_e;

  // Width that holds the sum of n unsigned w-bit values without overflow.
  function automatic int sum_width(input int n, input int w);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/lif_neuron_if.sv
// Bus between a LIF neuron and whatever drives its synaptic inputs and
// consumes its spike/membrane outputs.
interface lif_neuron_if import snn_pkg::*; #(
  parameter int NUM_PRE = DEF_NUM_PRE,
  parameter int W_WIDTH = DEF_W_WIDTH,
  parameter int V_WIDTH = DEF_V_WIDTH
);

  logic                         enable;
  logic [NUM_PRE-1:0]           pre_spike;
  logic [NUM_PRE*W_WIDTH-1:0]   weight;
  logic                         post_spike;
  logic [V_WIDTH-1:0]           membrane;
  logic                         refractory;
  logic [1:0]                   state;
  logic [SPIKE_CNT_W-1:0]       spike_count;

  modport master (
    output enable, pre_spike, weight,
    input  post_spike, membrane, refractory, state, spike_count
  );

  modport slave (
    input  enable, pre_spike, weight,
    output post_spike, membrane, refractory, state, spike_count
  );

endinterface

// File: rtl/syn_adder.sv
// Combinational masked sum of synaptic weights. Input 0 owns the most
// significant weight field, input NUM_PRE-1 the least significant one.
module syn_adder import snn_pkg::*; #(
  parameter int NUM_PRE = DEF_NUM_PRE,
  parameter int W_WIDTH = DEF_W_WIDTH,
  parameter int SUM_W   = sum_width(NUM_PRE, W_WIDTH)
) (
  input  logic [NUM_PRE-1:0]         i_pre_spike,
  input  logic [NUM_PRE*W_WIDTH-1:0] i_weight,
  output logic [SUM_W-1:0]           o_syn_sum
);

  logic [SUM_W-1:0] w_acc;

  // Accumulate the weight of every input that spiked this cycle.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      if (i_pre_spike[i]) begin
        w_acc = w_acc + SUM_W'(i_weight[(NUM_PRE-1-i)*W_WIDTH +: W_WIDTH]);
      end else begin
        w_acc = w_acc;
      end
    end
  end

  assign o_syn_sum = w_acc;

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: leak, saturating integration, threshold
// fire with a fixed refractory period, and a wrapping fire counter.
module lif_neuron import snn_pkg::*; #(
  parameter int NUM_PRE    = DEF_NUM_PRE,
  parameter int W_WIDTH    = DEF_W_WIDTH,
  parameter int V_WIDTH    = DEF_V_WIDTH,
  parameter int THRESHOLD  = 40,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 4
) (
  input  logic         clk,
  input  logic         rst,
  lif_neuron_if.slave  bus
);

  localparam int SUM_W = sum_width(NUM_PRE, W_WIDTH);
  // One bit of headroom over the wider operand so the add never wraps.
  localparam int EXT_W = ((V_WIDTH > SUM_W) ? V_WIDTH : SUM_W) + 1;
  localparam int CNT_W = $clog2(REFRACT + 1);

  localparam logic [EXT_W-1:0] V_MAX_EXT   = {{(EXT_W-V_WIDTH){1'b0}}, {V_WIDTH{1'b1}}};
  localparam logic [EXT_W-1:0] THR_EXT     = EXT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] REFRACT_CNT = CNT_W'(REFRACT);
  localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);

  lif_state_e             r_state;
  logic [V_WIDTH-1:0]     r_membrane;
  logic                   r_post_spike;
  logic                   r_refractory;
  logic [SPIKE_CNT_W-1:0] r_spike_count;
  logic [CNT_W-1:0]       r_refr_cnt;

  lif_state_e             w_state_nxt;
  logic [V_WIDTH-1:0]     w_membrane_nxt;
  logic                   w_post_nxt;
  logic [SPIKE_CNT_W-1:0] w_spike_count_nxt;
  logic [CNT_W-1:0]       w_refr_cnt_nxt;

  logic [SUM_W-1:0]       w_syn_sum;
  logic [V_WIDTH-1:0]     w_leaked;
  logic [EXT_W-1:0]       w_v_ext;
  logic [EXT_W-1:0]       w_v_sat;
  logic [V_WIDTH-1:0]     w_v_next;
  logic                   w_fire;

  syn_adder #(
    .NUM_PRE (NUM_PRE),
    .W_WIDTH (W_WIDTH),
    .SUM_W   (SUM_W)
  ) u_syn_adder (
    .i_pre_spike (bus.pre_spike),
    .i_weight    (bus.weight),
    .o_syn_sum   (w_syn_sum)
  );

  // Leak never underflows: v - (v >> k) is always >= 0.
  assign w_leaked = r_membrane - (r_membrane >> LEAK_SHIFT);
  assign w_v_ext  = EXT_W'(w_leaked) + EXT_W'(w_syn_sum);
  assign w_v_sat  = (w_v_ext > V_MAX_EXT) ? V_MAX_EXT : w_v_ext;
  assign w_v_next = w_v_sat[V_WIDTH-1:0];
  assign w_fire   = (w_v_sat >= THR_EXT);

  // Next-state and next-output decode for the neuron FSM.
  always_comb begin
    w_state_nxt       = r_state;
    w_membrane_nxt    = r_membrane;
    w_post_nxt        = 1'b0;
    w_spike_count_nxt = r_spike_count;
    w_refr_cnt_nxt    = r_refr_cnt;
    case (r_state)
      IDLE: begin
        if (bus.enable) begin
          w_state_nxt = INTEGRATE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      INTEGRATE: begin
        if (!bus.enable) begin
          // Inputs of the disabling cycle are discarded; membrane holds.
          w_state_nxt = IDLE;
        end else if (w_fire) begin
          w_state_nxt       = REFRACTORY;
          w_membrane_nxt    = '0;
          w_post_nxt        = 1'b1;
          w_spike_count_nxt = r_spike_count + 8'd1;
          w_refr_cnt_nxt    = REFRACT_CNT;
        end else begin
          w_membrane_nxt = w_v_next;
        end
      end
      REFRACTORY: begin
        // Countdown runs to completion regardless of enable.
        w_membrane_nxt = '0;
        if (r_refr_cnt <= ONE_CNT) begin
          w_refr_cnt_nxt = '0;
          if (bus.enable) begin
            w_state_nxt = INTEGRATE;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_refr_cnt_nxt = r_refr_cnt - ONE_CNT;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_membrane_nxt = '0;
        w_refr_cnt_nxt = '0;
      end
    endcase
  end

  // State and output registers; reset overrides any pending event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_membrane    <= '0;
      r_post_spike  <= 1'b0;
      r_refractory  <= 1'b0;
      r_spike_count <= '0;
      r_refr_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_membrane    <= w_membrane_nxt;
      r_post_spike  <= w_post_nxt;
      r_refractory  <= (w_state_nxt == REFRACTORY);
      r_spike_count <= w_spike_count_nxt;
      r_refr_cnt    <= w_refr_cnt_nxt;
    end
  end

  assign bus.post_spike  = r_post_spike;
  assign bus.membrane    = r_membrane;
  assign bus.refractory  = r_refractory;
  assign bus.state       = r_state;
  assign bus.spike_count = r_spike_count;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed self-checking bench for lif_neuron: a default-parameter instance
// and a high-threshold / weak-leak instance for the saturation case.
module tb_lif_neuron;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lif_neuron_if #(.NUM_PRE(4), .W_WIDTH(4), .V_WIDTH(8)) nif_a ();
  lif_neuron_if #(.NUM_PRE(4), .W_WIDTH(4), .V_WIDTH(8)) nif_b ();

  lif_neuron #(
    .NUM_PRE(4), .W_WIDTH(4), .V_WIDTH(8),
    .THRESHOLD(40), .LEAK_SHIFT(3), .REFRACT(4)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (nif_a)
  );

  lif_neuron #(
    .NUM_PRE(4), .W_WIDTH(4), .V_WIDTH(8),
    .THRESHOLD(255), .LEAK_SHIFT(7), .REFRACT(4)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (nif_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int st, input int mem,
                       input int post, input int refr, input int cnt);
    chk({tag, ".state"},      32'(nif_a.state),       32'(st));
    chk({tag, ".membrane"},   32'(nif_a.membrane),    32'(mem));
    chk({tag, ".post_spike"}, 32'(nif_a.post_spike),  32'(post));
    chk({tag, ".refractory"}, 32'(nif_a.refractory),  32'(refr));
    chk({tag, ".spike_count"},32'(nif_a.spike_count), 32'(cnt));
  endtask

  initial begin
    int exp_m[4];
    int exp_b[4];
    exp_m = '{10, 19, 27, 34};
    exp_b = '{60, 120, 180, 239};

    rst = 1'b1;
    nif_a.enable = 1'b0; nif_a.pre_spike = 4'h0; nif_a.weight = 16'h0000;
    nif_b.enable = 1'b0; nif_b.pre_spike = 4'h0; nif_b.weight = 16'h0000;
    tick();
    tick();
    chk_a("reset", 0, 0, 0, 0, 0);
    chk("reset_b.membrane", 32'(nif_b.membrane), 32'd0);
    chk("reset_b.state", 32'(nif_b.state), 32'd0);

    // Single weak input held: 10, 19, 27, 34, then fire.
    rst = 1'b0;
    nif_a.enable = 1'b1; nif_a.weight = 16'hAAAA; nif_a.pre_spike = 4'b0001;
    tick();
    chk("s1_enter.state", 32'(nif_a.state), 32'd1);
    chk("s1_enter.membrane", 32'(nif_a.membrane), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s1_ramp.membrane", 32'(nif_a.membrane), 32'(exp_m[i]));
    end
    tick();
    chk_a("s1_fire", 2, 0, 1, 1, 1);
    tick();
    chk_a("s1_no_b2b", 2, 0, 0, 1, 1);

    // Reset in the second refractory cycle.
    rst = 1'b1;
    tick();
    chk_a("rst_refr", 0, 0, 0, 0, 0);

    // One-cycle full-strength burst: sum 60, four refractory cycles.
    rst = 1'b0;
    nif_a.weight = 16'hFFFF; nif_a.pre_spike = 4'h0;
    tick();
    chk("s2_enter.state", 32'(nif_a.state), 32'd1);
    nif_a.pre_spike = 4'hF;
    tick();
    chk_a("s2_fire", 2, 0, 1, 1, 1);
    nif_a.pre_spike = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("s2_refr", 2, 0, 0, 1, 1);
    end
    tick();
    chk_a("s2_exit", 1, 0, 0, 0, 1);

    // Continuous drive: fire every 5 cycles, refractory spikes dropped.
    nif_a.pre_spike = 4'hF;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("s3_period.post_spike", 32'(nif_a.post_spike), 32'((k % 5) == 1));
      chk("s3_period.refractory", 32'(nif_a.refractory), 32'((k % 5) != 0));
    end
    chk("s3_count", 32'(nif_a.spike_count), 32'd4);
    nif_a.pre_spike = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    chk_a("s3_exit", 1, 0, 0, 0, 4);

    // Ramp to 34, disable, hold through 10 cycles of spikes, resume.
    nif_a.weight = 16'hAAAA; nif_a.pre_spike = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s4_ramp.membrane", 32'(nif_a.membrane), 32'(exp_m[i]));
    end
    nif_a.enable = 1'b0;
    tick();
    chk_a("s4_idle", 0, 34, 0, 0, 4);
    nif_a.pre_spike = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s4_hold.membrane", 32'(nif_a.membrane), 32'd34);
      chk("s4_hold.state", 32'(nif_a.state), 32'd0);
    end
    nif_a.enable = 1'b1; nif_a.pre_spike = 4'h0;
    tick();
    chk("s4_resume.state", 32'(nif_a.state), 32'd1);
    chk("s4_resume.membrane", 32'(nif_a.membrane), 32'd34);
    tick();
    chk("s4_leak.membrane", 32'(nif_a.membrane), 32'd30);

    // Reset in a threshold-crossing cycle: 30 - 3 + 20 = 47 would fire.
    nif_a.pre_spike = 4'b0011;
    rst = 1'b1;
    tick();
    chk_a("rst_fire", 0, 0, 0, 0, 0);

    // High threshold, weak leak: 239 - 1 + 60 saturates to 255 and fires.
    rst = 1'b0;
    nif_a.enable = 1'b0; nif_a.pre_spike = 4'h0;
    nif_b.enable = 1'b1; nif_b.weight = 16'hFFFF; nif_b.pre_spike = 4'hF;
    tick();
    chk("s5_enter.state", 32'(nif_b.state), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s5_ramp.membrane", 32'(nif_b.membrane), 32'(exp_b[i]));
    end
    tick();
    chk("s5_fire.post_spike", 32'(nif_b.post_spike), 32'd1);
    chk("s5_fire.membrane", 32'(nif_b.membrane), 32'd0);
    chk("s5_fire.spike_count", 32'(nif_b.spike_count), 32'd1);
    chk("s5_fire.state", 32'(nif_b.state), 32'd2);
    nif_b.enable = 1'b0; nif_b.pre_spike = 4'h0;

    // Weight field ordering: input 0 is the MSB nibble.
    nif_a.enable = 1'b1; nif_a.weight = 16'h1234; nif_a.pre_spike = 4'b0101;
    tick();
    chk("s6_enter.state", 32'(nif_a.state), 32'd1);
    tick();
    chk("s6_in02.membrane", 32'(nif_a.membrane), 32'd4);
    nif_a.pre_spike = 4'b1010;
    tick();
    chk("s6_in13.membrane", 32'(nif_a.membrane), 32'd10);
    nif_a.pre_spike = 4'b1000;
    tick();
    chk("s6_in3.membrane", 32'(nif_a.membrane), 32'd13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lif_neuron.md
LIF_NEURON -- requirements
Module: lif_neuron

Interface
REQ-001 SHALL have parameter NUM_PRE, default 4: number of presynaptic inputs.
REQ-002 SHALL have parameter W_WIDTH, default 4: bits per synaptic weight.
REQ-003 SHALL have parameter V_WIDTH, default 8: membrane potential width, unsigned.
REQ-004 SHALL have parameter THRESHOLD, default 40: firing threshold.
REQ-005 SHALL have parameter LEAK_SHIFT, default 3: leak is v >> LEAK_SHIFT per integrating cycle.
REQ-006 SHALL have parameter REFRACT, default 4: refractory length in cycles, at least 1.
REQ-007 SHALL use one clock and a synchronous, active-high reset.
REQ-008 clk  input  1  sole clock; all state updates on its rising edge.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 enable  input  1  integration enable.
REQ-011 pre_spike  input  NUM_PRE  presynaptic spike per input, one-cycle pulses.
REQ-012 weight  input  NUM_PRE*W_WIDTH  packed unsigned weights; input 0 in the MSB field ([15:12] at defaults), input 3 in the LSB field ([3:0]).
REQ-013 post_spike  output  1  registered one-cycle fire pulse; feeds the STDP stage's post_spike input.
REQ-014 membrane  output  V_WIDTH  registered membrane potential.
REQ-015 refractory  output  1  high while in REFRACTORY.
REQ-016 state  output  2  encoding: IDLE=0, INTEGRATE=1, REFRACTORY=2.
REQ-017 spike_count  output  8  total fires since reset; wraps from 255 to 0.

Function
REQ-018 SHALL implement the FSM states IDLE, INTEGRATE and REFRACTORY.
REQ-019 IDLE: SHALL hold membrane, with no leak and no integration; SHALL go to INTEGRATE on the first cycle enable=1.
REQ-020 INTEGRATE: syn_sum = sum of weight[i] over all i where pre_spike[i]=1, computed at full width with no overflow.
REQ-021 INTEGRATE: v_next = membrane - (membrane >> LEAK_SHIFT) + syn_sum, saturating at 2^V_WIDTH-1.
REQ-022 INTEGRATE, if v_next >= THRESHOLD: next cycle post_spike=1, membrane=0, spike_count+1, state REFRACTORY with the counter loaded to REFRACT.
REQ-023 INTEGRATE, otherwise: membrane=v_next, post_spike=0.
REQ-024 Latency: pre_spike sampled at edge N SHALL be reflected in membrane and post_spike after edge N, i.e. one cycle.
REQ-025 REFRACTORY: SHALL ignore pre_spike, hold membrane at 0 and decrement the counter each cycle.
REQ-026 REFRACTORY: SHALL leave the state after exactly REFRACT cycles, to INTEGRATE if enable=1, else to IDLE.
REQ-027 enable=0 during INTEGRATE: SHALL go to IDLE next cycle, ignore that cycle's inputs and hold membrane.
REQ-028 enable=0 during REFRACTORY: SHALL NOT abort the refractory countdown.
REQ-029 post_spike SHALL never be high on two consecutive cycles.
REQ-030 Minimum inter-spike interval SHALL be REFRACT+1 cycles.
REQ-031 refractory SHALL equal (state==REFRACTORY).
REQ-032 pre_spike asserted in IDLE or REFRACTORY SHALL be dropped, not queued.

Reset
REQ-033 rst=1 SHALL, at the next edge, force state=IDLE, membrane=0, post_spike=0, refractory=0, spike_count=0 and refractory counter=0.
REQ-034 Reset SHALL take priority over every event, including a threshold crossing in the same cycle and mid-refractory operation.
REQ-035 The first integration after reset release SHALL need enable=1 and SHALL occur one cycle after IDLE to INTEGRATE.

Structure
REQ-036 Package snn_pkg SHALL hold the state enum (IDLE, INTEGRATE, REFRACTORY) and the default widths NUM_PRE, W_WIDTH and V_WIDTH, shared with the STDP stage.
REQ-037 Sub-module syn_adder SHALL be the combinational masked weight summation, parameterised by NUM_PRE and W_WIDTH.
REQ-038 The FSM, leak, saturation and counters SHALL reside in lif_neuron.

Verification
REQ-039 Scenario, defaults: reset, enable=1, weight=16'hAAAA, pre_spike=4'b0001 held -> membrane 10, 19, 27, 34; post_spike=1 on the 5th integrating cycle; membrane=0.
REQ-040 Scenario: weight=16'hFFFF, pre_spike=4'hF for one cycle from membrane 0 -> syn_sum=60; post_spike next cycle; refractory=1 for exactly 4 cycles; spike_count=1.
REQ-041 Scenario: pre_spike=4'hF held continuously with weight=16'hFFFF -> post_spike period 5 cycles; no back-to-back pulses; spikes during refractory dropped.
REQ-042 Scenario: membrane=34, enable dropped -> IDLE; membrane stays 34 for 10 cycles despite pre_spike; re-enable resumes from 34.
REQ-043 Scenario: rst asserted in the 2nd refractory cycle, and separately in a threshold-crossing cycle -> next cycle all outputs at reset values; no post_spike.
REQ-044 Scenario: THRESHOLD=255, LEAK_SHIFT=7, weight=16'hFFFF, pre_spike=4'hF held -> membrane saturates at 255 with no wrap, then fires.
